// File: rtl/ysyx_25060170_mem_arbiter_if.sv
// Bus bundle between the IFU, the LSU, the shared memory port and the arbiter.
// The master modport is the arbiter's view; the slave modport is the clients/memory view.
interface ysyx_25060170_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_addr;
  logic                  ifu_rsp_valid;
  logic [DATA_W-1:0]     ifu_rdata;
  logic                  ifu_rsp_err;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_W-1:0]     lsu_addr;
  logic                  lsu_wen;
  logic [DATA_W-1:0]     lsu_wdata;
  logic [DATA_W/8-1:0]   lsu_wmask;
  logic                  lsu_rsp_valid;
  logic [DATA_W-1:0]     lsu_rdata;
  logic                  lsu_rsp_err;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_rsp_valid;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_25060170_mem_arbiter.sv
// Round-robin IFU/LSU arbiter for a single memory port: one transaction in flight,
// response routed back to its owner, error response if memory exceeds TIMEOUT cycles.
module ysyx_25060170_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_25060170_mem_arbiter_if.master bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

  state_e              state, state_nxt;
  owner_e              owner, owner_nxt, last_owner, last_owner_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic                wen_q, wen_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic [MASK_W-1:0]   wmask_q, wmask_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;

  logic                ifu_rsp_valid_q, ifu_rsp_valid_nxt;
  logic                lsu_rsp_valid_q, lsu_rsp_valid_nxt;
  logic                rsp_err_q, rsp_err_nxt;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_nxt;

  logic ifu_grant, lsu_grant, finish, timeout_hit;

  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      owner           <= OWN_IFU;
      last_owner      <= OWN_IFU;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      cnt_q           <= '0;
      ifu_rsp_valid_q <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_rdata_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state           <= state_nxt;
      owner           <= owner_nxt;
      last_owner      <= last_owner_nxt;
      addr_q          <= addr_nxt;
      wen_q           <= wen_nxt;
      wdata_q         <= wdata_nxt;
      wmask_q         <= wmask_nxt;
      cnt_q           <= cnt_nxt;
      ifu_rsp_valid_q <= ifu_rsp_valid_nxt;
      lsu_rsp_valid_q <= lsu_rsp_valid_nxt;
      rsp_err_q       <= rsp_err_nxt;
      rsp_rdata_q     <= rsp_rdata_nxt;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_nxt         = state;
    owner_nxt         = owner;
    last_owner_nxt    = last_owner;
    addr_nxt          = addr_q;
    wen_nxt           = wen_q;
    wdata_nxt         = wdata_q;
    wmask_nxt         = wmask_q;
    cnt_nxt           = cnt_q;
    ifu_grant         = 1'b0;
    lsu_grant         = 1'b0;
    finish            = 1'b0;
    ifu_rsp_valid_nxt = 1'b0;
    lsu_rsp_valid_nxt = 1'b0;
    rsp_err_nxt       = 1'b0;
    rsp_rdata_nxt     = '0;

    case (state)
      S_IDLE: begin
        // On a tie the requester that did not go last wins.
        if (bus.lsu_req_valid && (!bus.ifu_req_valid || last_owner == OWN_IFU)) begin
          lsu_grant      = 1'b1;
          owner_nxt      = OWN_LSU;
          last_owner_nxt = OWN_LSU;
          addr_nxt       = bus.lsu_addr;
          wen_nxt        = bus.lsu_wen;
          wdata_nxt      = bus.lsu_wdata;
          wmask_nxt      = bus.lsu_wmask;
        end else if (bus.ifu_req_valid) begin
          ifu_grant      = 1'b1;
          owner_nxt      = OWN_IFU;
          last_owner_nxt = OWN_IFU;
          addr_nxt       = bus.ifu_addr;
          wen_nxt        = 1'b0;
          wdata_nxt      = '0;
          wmask_nxt      = '0;
        end
        if (ifu_grant || lsu_grant) begin
          cnt_nxt   = '0;
          state_nxt = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        cnt_nxt = cnt_q + 1'b1;
        // A response is only taken in WAIT; one arriving with the handshake is ignored.
        if (state == S_WAIT && bus.mem_rsp_valid) begin
          finish        = 1'b1;
          rsp_rdata_nxt = wen_q ? '0 : bus.mem_rdata;
        end else if (timeout_hit) begin
          finish      = 1'b1;
          rsp_err_nxt = 1'b1;
        end else if (state == S_REQ && bus.mem_req_ready) begin
          state_nxt = S_WAIT;
        end
        if (finish) begin
          state_nxt         = S_IDLE;
          ifu_rsp_valid_nxt = (owner == OWN_IFU);
          lsu_rsp_valid_nxt = (owner == OWN_LSU);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grants are combinational, so reset must mask them for outputs to read 0 at once.
  assign bus.ifu_req_ready = rst_n & ifu_grant;
  assign bus.lsu_req_ready = rst_n & lsu_grant;

  assign bus.mem_req_valid = (state == S_REQ);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;

  assign bus.ifu_rsp_valid = ifu_rsp_valid_q;
  assign bus.ifu_rdata     = ifu_rsp_valid_q ? rsp_rdata_q : '0;
  assign bus.ifu_rsp_err   = ifu_rsp_valid_q & rsp_err_q;
  assign bus.lsu_rsp_valid = lsu_rsp_valid_q;
  assign bus.lsu_rdata     = lsu_rsp_valid_q ? rsp_rdata_q : '0;
  assign bus.lsu_rsp_err   = lsu_rsp_valid_q & rsp_err_q;
endmodule

// File: tb/tb_ysyx_25060170_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: directed sequences, a grant
// vector table, and randomized traffic against a cycle-number transaction model.
module tb_ysyx_25060170_mem_arbiter;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_25060170_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_25060170_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ifu_v;
    logic        lsu_v;
    logic        lsu_wen;
    logic [31:0] mem_rdata;
    logic        exp_ifu_rdy;
    logic        exp_lsu_rdy;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = '0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  function automatic logic any_output();
    return |{bus.ifu_req_ready, bus.ifu_rsp_valid, bus.ifu_rdata, bus.ifu_rsp_err,
             bus.lsu_req_ready, bus.lsu_rsp_valid, bus.lsu_rdata, bus.lsu_rsp_err,
             bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};
  endfunction

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check("reset_outputs_zero", 64'(any_output()), 64'd0);
    rst_n = 1'b1;
  endtask

  // Called in a grant cycle; ends settled in the response-pulse cycle (grant + 3).
  task automatic quick_mem(input logic [31:0] rdata, input logic drop);
    tick();
    if (drop) begin
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
    end
    bus.mem_req_ready = 1'b1;
    settle();
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = rdata;
    settle();
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;
    settle();
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Random-phase model state: one transaction described by its cycle numbers.
  bit          busy, ok, own_lsu, last_lsu, pulse, p_lsu;
  bit          ifu_pend, lsu_pend, ifu_out, lsu_out, g_ifu, g_lsu, in_req, in_wait;
  int          g, hs, rs, p, d1, d2;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic        e_wen;
  logic [3:0]  e_wmask;
  logic [33:0] exp_ifu, exp_lsu;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0013, 1'b1, 1'b0, 32'h0000_0013};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h1111_1111, 1'b0, 1'b1, 32'h1111_1111};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h2222_2222};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 1'b1, 32'h0000_0000};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h4444_4444, 1'b0, 1'b1, 32'h4444_4444};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h5555_5555, 1'b1, 1'b0, 32'h5555_5555};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h6666_6666, 1'b1, 1'b0, 32'h6666_6666};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h7777_7777, 1'b0, 1'b1, 32'h0000_0000};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 32'h8888_8888, 1'b0, 1'b0, 32'h0000_0000};

    idle_inputs();
    do_reset();

    // Single IFU fetch with an immediately ready memory.
    tick();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    settle();
    check("fetch_ifu_ready_T", 64'(bus.ifu_req_ready), 64'd1);
    check("fetch_lsu_ready_T", 64'(bus.lsu_req_ready), 64'd0);
    tick();
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = 32'h1234_5678;
    bus.mem_req_ready = 1'b1;
    settle();
    check("fetch_mem_valid_T1", 64'(bus.mem_req_valid), 64'd1);
    check("fetch_mem_addr_T1", 64'(bus.mem_addr), 64'h8000_0000);
    check("fetch_mem_wen_wmask", 64'({bus.mem_wen, bus.mem_wdata, bus.mem_wmask}), 64'd0);
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h0010_0093;
    settle();
    check("fetch_no_early_rsp", 64'(bus.ifu_rsp_valid), 64'd0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;
    settle();
    check("fetch_rsp_T3", 64'({bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.ifu_rdata}),
          64'({1'b1, 1'b0, 32'h0010_0093}));
    check("fetch_lsu_quiet", 64'({bus.lsu_req_ready, bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.lsu_rdata}), 64'd0);
    tick();
    settle();
    check("fetch_rsp_one_cycle", 64'({bus.ifu_rsp_valid, bus.ifu_rdata}), 64'd0);

    // Grant decisions driven from the vector table.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick();
      bus.ifu_req_valid = vecs[i].ifu_v;
      bus.ifu_addr      = 32'h8000_0000 + 32'(i * 4);
      bus.lsu_req_valid = vecs[i].lsu_v;
      bus.lsu_addr      = 32'h8000_1000 + 32'(i * 8);
      bus.lsu_wen       = vecs[i].lsu_wen;
      bus.lsu_wdata     = $urandom;
      bus.lsu_wmask     = 4'hF;
      settle();
      check($sformatf("vec%0d_ifu_ready", i), 64'(bus.ifu_req_ready), 64'(vecs[i].exp_ifu_rdy));
      check($sformatf("vec%0d_lsu_ready", i), 64'(bus.lsu_req_ready), 64'(vecs[i].exp_lsu_rdy));
      if (vecs[i].exp_ifu_rdy || vecs[i].exp_lsu_rdy) begin
        quick_mem(vecs[i].mem_rdata, 1'b1);
        check($sformatf("vec%0d_ifu_rsp", i), 64'({bus.ifu_rsp_valid, bus.ifu_rdata}),
              64'({vecs[i].exp_ifu_rdy, vecs[i].exp_ifu_rdy ? vecs[i].exp_rdata : 32'd0}));
        check($sformatf("vec%0d_lsu_rsp", i), 64'({bus.lsu_rsp_valid, bus.lsu_rdata}),
              64'({vecs[i].exp_lsu_rdy, vecs[i].exp_lsu_rdy ? vecs[i].exp_rdata : 32'd0}));
      end
    end
    idle_inputs();

    // Back-to-back ties after reset alternate LSU, IFU, LSU.
    do_reset();
    tick();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0100;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_2000;
    settle();
    check("tie0_ifu_ready", 64'(bus.ifu_req_ready), 64'd0);
    check("tie0_lsu_ready", 64'(bus.lsu_req_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.mem_req_ready = 1'b1;
      settle();
      check($sformatf("tie%0d_ready_busy", k), 64'({bus.ifu_req_ready, bus.lsu_req_ready}), 64'd0);
      check($sformatf("tie%0d_mem_addr", k), 64'(bus.mem_addr),
            (k == 1) ? 64'h8000_0100 : 64'h8000_2000);
      tick();
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rdata     = 32'hA000_0000 + 32'(k);
      settle();
      tick();
      bus.mem_rsp_valid = 1'b0;
      if (k == 2) begin
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
      end
      settle();
      check($sformatf("tie%0d_rsp", k), 64'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}),
            (k == 1) ? 64'b10 : 64'b01);
      if (k < 2)
        check($sformatf("tie%0d_next_grant", k), 64'({bus.ifu_req_ready, bus.lsu_req_ready}),
              (k == 0) ? 64'b10 : 64'b01);
    end
    idle_inputs();

    // Store with memory stalling the request for 4 cycles.
    tick();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_1000;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 32'hDEAD_BEEF;
    bus.lsu_wmask     = 4'hF;
    settle();
    check("store_lsu_ready", 64'(bus.lsu_req_ready), 64'd1);
    tick();
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = 32'h0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = 32'h0;
    bus.lsu_wmask     = 4'h0;
    for (int s = 0; s < 5; s++) begin
      bus.mem_req_ready = (s == 4);
      settle();
      check($sformatf("store_hold%0d_valid", s), 64'(bus.mem_req_valid), 64'd1);
      check($sformatf("store_hold%0d_fields", s),
            64'({bus.mem_addr, bus.mem_wen, bus.mem_wmask, bus.mem_wdata[31:4]}),
            64'({32'h8000_1000, 1'b1, 4'hF, 28'hDEAD_BEE}));
      tick();
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h1234_5678;
    settle();
    check("store_wait_no_rsp", 64'(bus.lsu_rsp_valid), 64'd0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    settle();
    check("store_rsp", 64'({bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.lsu_rdata}), 64'({1'b1, 1'b0, 32'd0}));
    idle_inputs();

    // Memory accepts but never responds: error pulse 8 cycles after REQ begins.
    tick();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_3000;
    bus.mem_rdata     = 32'hCAFE_F00D;
    settle();
    check("tmo_lsu_ready", 64'(bus.lsu_req_ready), 64'd1);
    for (int c = 1; c <= 9; c++) begin
      tick();
      bus.lsu_req_valid = 1'b0;
      bus.mem_req_ready = (c == 1);
      settle();
      check($sformatf("tmo_c%0d_lsu_rsp", c), 64'({bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.lsu_rdata}),
            (c == 9) ? 64'({1'b1, 1'b1, 32'd0}) : 64'd0);
    end
    check("tmo_ifu_quiet", 64'(bus.ifu_rsp_valid), 64'd0);
    tick();
    bus.mem_rsp_valid = 1'b1;
    settle();
    tick();
    bus.mem_rsp_valid = 1'b0;
    settle();
    check("tmo_late_rsp_dropped", 64'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 64'd0);
    tick();
    settle();
    check("tmo_late_rsp_dropped2", 64'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 64'd0);
    idle_inputs();

    // Reset while an LSU transaction sits in WAIT.
    tick();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_4000;
    settle();
    check("rstw_lsu_ready", 64'(bus.lsu_req_ready), 64'd1);
    tick();
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    tick();
    bus.mem_req_ready = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_5000;
    bus.lsu_req_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_outputs_zero_now", 64'(any_output()), 64'd0);
    tick();
    settle();
    check("rstw_outputs_zero_held", 64'(any_output()), 64'd0);
    tick();
    rst_n = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h5555_AAAA;
    settle();
    check("rstw_tie_grants_lsu", 64'({bus.ifu_req_ready, bus.lsu_req_ready}), 64'b01);
    check("rstw_stale_ignored", 64'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 64'd0);
    tick();
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    check("rstw_ready_low_in_req", 64'({bus.ifu_req_ready, bus.lsu_req_ready}), 64'd0);
    tick();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    settle();
    check("rstw_handshake_rsp_ignored", 64'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 64'd0);
    tick();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'hABCD_0123;
    settle();
    tick();
    bus.mem_rsp_valid = 1'b0;
    settle();
    check("rstw_after_rsp", 64'({bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.lsu_rdata}),
          64'({1'b1, 1'b0, 32'hABCD_0123}));
    idle_inputs();

    // Randomized traffic against the transaction-level model.
    do_reset();
    busy = 0; last_lsu = 0; own_lsu = 0; ok = 0;
    ifu_pend = 0; lsu_pend = 0; ifu_out = 0; lsu_out = 0;
    g = 0; hs = 0; rs = 0; p = 0;
    e_rdata = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      pulse = busy && (cyc == p);
      p_lsu = own_lsu;
      if (pulse) begin
        busy = 0;
        if (own_lsu) lsu_out = 0;
        else         ifu_out = 0;
      end
      if (!ifu_pend && !ifu_out && $urandom_range(0, 2) == 0) begin
        ifu_pend     = 1;
        bus.ifu_addr = $urandom;
      end
      if (!lsu_pend && !lsu_out && $urandom_range(0, 2) == 0) begin
        lsu_pend      = 1;
        bus.lsu_addr  = $urandom;
        bus.lsu_wen   = 1'($urandom_range(0, 1));
        bus.lsu_wdata = $urandom;
        bus.lsu_wmask = 4'($urandom_range(0, 15));
      end
      bus.ifu_req_valid = ifu_pend;
      bus.lsu_req_valid = lsu_pend;
      g_lsu   = !busy && lsu_pend && (!ifu_pend || !last_lsu);
      g_ifu   = !busy && ifu_pend && !g_lsu;
      in_req  = busy && (cyc > g) && (cyc <= imin(hs, g + TIMEOUT));
      in_wait = busy && (cyc > hs) && (cyc < p);
      bus.mem_req_ready = in_req ? (cyc == hs) : 1'($urandom_range(0, 1));
      bus.mem_rdata     = $urandom;
      if (in_wait) bus.mem_rsp_valid = ok && (cyc == rs);
      else         bus.mem_rsp_valid = ($urandom_range(0, 3) == 0);
      if (in_wait && ok && cyc == rs) e_rdata = e_wen ? 32'd0 : bus.mem_rdata;
      settle();

      exp_ifu = (pulse && !p_lsu) ? {1'b1, !ok, e_rdata} : 34'd0;
      exp_lsu = (pulse &&  p_lsu) ? {1'b1, !ok, e_rdata} : 34'd0;
      check("rnd_ifu_ready", 64'(bus.ifu_req_ready), 64'(g_ifu));
      check("rnd_lsu_ready", 64'(bus.lsu_req_ready), 64'(g_lsu));
      check("rnd_ifu_rsp", 64'({bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.ifu_rdata}), 64'(exp_ifu));
      check("rnd_lsu_rsp", 64'({bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.lsu_rdata}), 64'(exp_lsu));
      check("rnd_mem_req_valid", 64'(bus.mem_req_valid), 64'(in_req));
      if (in_req) begin
        check("rnd_mem_addr_mask", 64'({bus.mem_addr, bus.mem_wmask}), 64'({e_addr, e_wmask}));
        check("rnd_mem_wen_wdata", 64'({bus.mem_wen, bus.mem_wdata}), 64'({e_wen, e_wdata}));
      end

      if (g_lsu || g_ifu) begin
        busy     = 1;
        g        = cyc;
        own_lsu  = g_lsu;
        last_lsu = g_lsu;
        e_rdata  = '0;
        if (g_lsu) begin
          e_addr  = bus.lsu_addr;
          e_wen   = bus.lsu_wen;
          e_wdata = bus.lsu_wdata;
          e_wmask = bus.lsu_wmask;
          lsu_pend = 0;
          lsu_out  = 1;
        end else begin
          e_addr  = bus.ifu_addr;
          e_wen   = 1'b0;
          e_wdata = '0;
          e_wmask = '0;
          ifu_pend = 0;
          ifu_out  = 1;
        end
        d1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TIMEOUT + 1)) : int'($urandom_range(0, 2));
        d2 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TIMEOUT + 1)) : int'($urandom_range(0, 2));
        hs = g + 1 + d1;
        rs = hs + 1 + d2;
        ok = (rs <= g + TIMEOUT);
        p  = ok ? rs + 1 : g + TIMEOUT + 1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_25060170_mem_arbiter.md
# ysyx_25060170_mem_arbiter

Two-requester memory arbiter for the multi-cycle NPC core: shares one memory port between the IFU (instruction fetch) and the LSU (load/store). It accepts one transaction at a time, forwards it to memory, routes the response back to the owner, and returns an error response if memory does not complete within a bounded time. It sits between IFU/LSU and the DPI-backed memory model.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles in REQ+WAIT before error response; 0 disables timeout
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_rsp_valid  out  1  one-cycle response pulse to IFU
- ifu_rdata  out  DATA_W  fetched instruction
- ifu_rsp_err  out  1  timeout error, qualified by ifu_rsp_valid
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  access address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte strobes
- lsu_rsp_valid  out  1  one-cycle response pulse to LSU
- lsu_rdata  out  DATA_W  load data; 0 for stores
- lsu_rsp_err  out  1  timeout error, qualified by lsu_rsp_valid
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- mem_rsp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, REQ, WAIT. Registers: owner (IFU/LSU), last_owner, latched request fields, counter ($clog2(TIMEOUT+1) bits).
- IDLE: if only one requester is valid, grant it. If both are valid, grant the one that is not last_owner (round-robin). The granted *_req_ready is combinational and high in the same cycle. Fields are latched, owner and last_owner are set, counter is cleared, and the state moves to REQ. The non-granted ready stays 0.
- IFU requests are latched with wen=0, wdata=0, wmask=0.
- REQ: mem_req_valid=1 with latched fields held stable. When mem_req_ready=1, move to WAIT.
- WAIT: on mem_req_ready... when mem_rsp_valid=1, register owner's rsp_valid=1, err=0, and rdata = mem_rdata (0 if wen), then go to IDLE.
- Timeout (TIMEOUT>0): counter increments every cycle in REQ/WAIT. When the counter reaches TIMEOUT-1 without completion, the owner gets rsp_valid=1, err=1, rdata=0, and the state goes to IDLE.
- mem_rsp_valid is ignored in IDLE and REQ, so stale responses after a timeout are dropped.
- *_req_ready is never high outside IDLE.
- At most one rsp_valid is high in any cycle.
- Reset, asynchronous including mid-transaction:
  - state=IDLE, last_owner=IFU (the first tie grants LSU), counter=0.
  - All outputs are 0.
  - The abandoned transaction produces no response.

## Timing
- Accept at cycle T (ready high). mem_req_valid is high from T+1.
- With mem_req_ready=1 at T+1 and mem_rsp_valid=1 at T+2, rsp_valid pulses at T+3 for exactly one cycle.
- State is IDLE during the rsp_valid cycle, so a new grant may occur in that same cycle. Minimum spacing between grants is 3 cycles.
- mem_rsp_valid in the cycle of the mem_req handshake is not sampled. It is only sampled from the following cycle on.
- rsp outputs are registered. rdata/err hold their value only during the pulse and are 0 otherwise.

## Test plan
- Single IFU fetch of 0x80000000, memory ready at once, rsp next cycle with 0x00100093: ifu_req_ready at T, mem_addr=0x80000000 at T+1, ifu_rsp_valid with rdata 0x00100093 at T+3, lsu outputs stay 0.
- Simultaneous IFU and LSU requests after reset: LSU granted first. IFU stays unready until the LSU response cycle, then is granted. Three back-to-back ties alternate LSU, IFU, LSU.
- LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, with mem_req_ready held low 4 cycles: mem fields stable all 4 cycles, lsu_rsp_valid with rdata 0 and err 0 after the response.
- TIMEOUT=8, memory never responds: lsu_rsp_valid with err=1 and rdata=0 exactly 8 cycles after entering REQ. A late mem_rsp_valid afterwards causes no pulse.
- rst_n asserted while in WAIT: all outputs 0 immediately. A pending mem_rsp_valid after release is ignored, and the next tie grants LSU.
